// File: rtl/tone_pkg.sv
// tone_pkg: shared types, widths and the 50 MHz pitch table for note_tone_gen.
package tone_pkg;
  localparam int NOTE_W = 4;
  localparam int AMP_W = 8;
  localparam int REF_HZ = 50_000_000;
  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;
  // Half periods in REF_HZ clocks for C4..C6; entry 0 is the rest code.
  localparam logic [16:0] HALF_PERIOD [16] = '{
    17'd0,     17'd95556, 17'd85131, 17'd75843, 17'd71586, 17'd63776, 17'd56818, 17'd50619,
    17'd47778, 17'd42566, 17'd37922, 17'd35793, 17'd31888, 17'd28409, 17'd25310, 17'd23889
  };
  // Rescales the reference table to another clock, rounding to nearest.
  function automatic logic [16:0] half_period(input longint clk_hz, input logic [NOTE_W-1:0] n);
    return 17'((longint'(HALF_PERIOD[n]) * clk_hz + REF_HZ / 2) / REF_HZ);
  endfunction
endpackage

// File: rtl/note_sync.sv
// note_sync: two-flop synchroniser with a stability compare; cur_note shows the new code during the note_chg cycle.
module note_sync
  import tone_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NOTE_W-1:0] note,
  output logic [NOTE_W-1:0] cur_note,
  output logic              note_chg
);
  logic [NOTE_W-1:0] s1, s2, s3, held;
  assign note_chg = (s2 == s3) && (s2 != held);
  assign cur_note = note_chg ? s2 : held;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {s1, s2, s3, held} <= '0;
    end else begin
      s1 <= note;
      s2 <= s1;
      s3 <= s2;
      held <= cur_note;
    end
  end
endmodule

// File: rtl/note_tone_gen.sv
// note_tone_gen: note-driven square wave with attack/sustain/release envelope, tone pin and PCM samples.
module note_tone_gen
  import tone_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int SAMPLE_DIV = 1042,
  parameter int ENV_TICK = 50_000,
  parameter int ATTACK_STEP = 8,
  parameter int RELEASE_STEP = 4
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic [NOTE_W-1:0] note,
  input  logic              mute,
  output logic              tone_out,
  output logic [15:0]       sample,
  output logic              sample_valid,
  output logic              busy
);
  localparam int SW = $clog2(SAMPLE_DIV);
  localparam int EW = $clog2(ENV_TICK);
  logic [NOTE_W-1:0] cur_note;
  logic note_chg, retune, etick, stick, level;
  logic [16:0] hp_tab [16];
  logic [16:0] phase, period;
  logic [AMP_W-1:0] amp, amp_nx;
  logic [AMP_W:0] up, dn;
  logic [SW-1:0] scnt;
  logic [EW-1:0] ecnt;
  logic [15:0] mag, smp;
  state_t state, st_acc, st_nx;
  for (genvar i = 0; i < 16; i++) begin : g_hp
    assign hp_tab[i] = half_period(longint'(CLK_HZ), NOTE_W'(i));
  end
  note_sync u_sync (
    .clk(CLOCK_50),
    .rst_n(rst_n),
    .note(note),
    .cur_note(cur_note),
    .note_chg(note_chg)
  );
  assign retune = note_chg && (cur_note != '0);
  assign etick = ecnt == EW'(ENV_TICK - 1);
  assign stick = scnt == SW'(SAMPLE_DIV - 1);
  assign busy = state != IDLE;
  assign tone_out = level & |amp & ~mute;
  // Note acceptance resolves first; an envelope tick then steps the resulting state.
  always_comb begin
    st_acc = !note_chg ? state : retune ? ATTACK : (state == IDLE) ? IDLE : RELEASE;
    up = {1'b0, amp} + (AMP_W + 1)'(ATTACK_STEP);
    dn = {1'b0, amp} - (AMP_W + 1)'(RELEASE_STEP);
    amp_nx = !etick ? amp
           : (st_acc == ATTACK) ? (up[AMP_W] ? '1 : up[AMP_W-1:0])
           : (st_acc == RELEASE) ? (dn[AMP_W] ? '0 : dn[AMP_W-1:0])
           : amp;
    st_nx = (etick && st_acc == ATTACK && amp_nx == '1) ? SUSTAIN
          : (etick && st_acc == RELEASE && amp_nx == '0) ? IDLE
          : st_acc;
    mag = {1'b0, amp, 7'b0};
    smp = mute ? 16'd0 : level ? mag : -mag;
  end
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      amp <= '0;
      level <= 1'b0;
      phase <= '0;
      period <= '0;
    end else begin
      state <= st_nx;
      amp <= amp_nx;
      if (retune) begin
        period <= hp_tab[cur_note];
        phase <= hp_tab[cur_note] - 17'd1;
        level <= 1'b1;
      end else if (state != IDLE) begin
        level <= (phase == '0) ? ~level : level;
        phase <= (phase == '0) ? period - 17'd1 : phase - 17'd1;
      end
    end
  end
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      ecnt <= '0;
      scnt <= '0;
      sample <= '0;
      sample_valid <= 1'b0;
    end else begin
      ecnt <= etick ? '0 : ecnt + EW'(1);
      scnt <= stick ? '0 : scnt + SW'(1);
      sample_valid <= stick;
      if (stick) sample <= smp;
    end
  end
endmodule

// File: tb/tb_note_tone_gen.sv
// tb_note_tone_gen: directed checks on a 1 MHz-scaled build (A4=1136, C4=1911, E4=1517, C5=956, C6=478 half periods).
module tb_note_tone_gen;
  import tone_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, mute = 1'b0;
  logic tone_out, sample_valid, busy;
  logic [3:0] note = 4'd0;
  logic [15:0] sample;
  int vec = 0, miss = 0, cyc = 0;

  note_tone_gen #(
    .CLK_HZ(1_000_000), .SAMPLE_DIV(20), .ENV_TICK(40), .ATTACK_STEP(8), .RELEASE_STEP(4)
  ) dut (
    .CLOCK_50(clk), .rst_n(rst_n), .note(note), .mute(mute),
    .tone_out(tone_out), .sample(sample), .sample_valid(sample_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vec++;
    if (got != exp) begin
      miss++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  function automatic int smp();
    return int'($signed(sample));
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tone", tone_out, 0);
    chk("rst_sample", smp(), 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    cyc = 0;
    go(19); chk("sv_early", sample_valid, 0);
    go(20); chk("sv_first", sample_valid, 1); chk("smp_idle", smp(), 0);
    go(21); chk("sv_pulse", sample_valid, 0);
    // A4 attack: accepted at edge 25, envelope ticks every 40 edges
    note = 4'd6;
    go(24); chk("lat_pre", busy, 0);
    go(25); chk("busy_rise", busy, 1);
    go(39); chk("tone_amp0", tone_out, 0);
    go(40); chk("tone_start", tone_out, 1);
    go(1160); chk("a4_hi", tone_out, 1);
    go(1161); chk("a4_fall", tone_out, 0);
    go(1240); chk("att_240", smp(), -30720);
    go(1280); chk("att_248", smp(), -31744);
    go(1300); chk("sus_neg", smp(), -32640);
    go(2296); chk("a4_lo", tone_out, 0);
    go(2297); chk("a4_rise", tone_out, 1);
    go(2300); chk("sus_pos", smp(), 32640);
    // release to idle
    note = 4'd0;
    go(2340); chk("rel_251", smp(), 32128);
    go(2380); chk("rel_247", smp(), 31616);
    go(4839); chk("rel_busy", busy, 1);
    go(4840); chk("rel_idle", busy, 0);
    go(4860); chk("idle_smp", smp(), 0);
    // C4 to sustain, then retrigger to C5
    note = 4'd1;
    go(6800); note = 4'd8;
    go(6803); chk("pre_retrig", tone_out, 0);
    go(6804); chk("retrig_lvl", tone_out, 1); chk("retrig_att", int'(dut.state), int'(ATTACK));
    go(6820); chk("retrig_amp", smp(), 32640);
    go(6839); chk("retrig_hold", int'(dut.state), int'(ATTACK));
    go(6840); chk("retrig_sus", int'(dut.state), int'(SUSTAIN));
    go(7759); chk("c5_hi", tone_out, 1);
    go(7760); chk("c5_fall", tone_out, 0);
    // mute for ten samples
    go(8700); mute = 1'b1;
    go(8720); chk("mute_tone", tone_out, 0);
    for (int i = 0; i < 10; i++) begin
      go(8720 + 20 * i);
      chk("mute_sv", sample_valid, 1);
      chk("mute_smp", smp(), 0);
    end
    mute = 1'b0;
    go(8920); chk("unmute_smp", smp(), 32640);
    go(9671); chk("unmute_hi", tone_out, 1);
    go(9672); chk("unmute_fall", tone_out, 0);
    // E4, then a one-cycle glitch to 5 that must be ignored
    go(9700); note = 4'd3;
    go(10000); note = 4'd5;
    go(10001); note = 4'd3;
    go(11220); chk("glitch_hi", tone_out, 1);
    go(11221); chk("glitch_fall", tone_out, 0);
    // reset while C6 is attacking
    go(11300); note = 4'd15;
    go(11304); chk("c6_tone", tone_out, 1);
    go(11310);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tone", tone_out, 0);
    chk("mid_rst_smp", smp(), 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sv", sample_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    go(3); chk("rst_lat_pre", busy, 0);
    go(4); chk("rst_busy", busy, 1);
    go(481); chk("c6_hi", tone_out, 1);
    go(482); chk("c6_fall", tone_out, 0);
    go(959); chk("c6_lo", tone_out, 0);
    go(960); chk("c6_rise", tone_out, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/note_tone_gen.md
# note_tone_gen

Downstream audio stage of the music player: consumes the 4-bit note code produced by the playback sequencer and turns it into an audible signal. It synchronises the note code into the 50 MHz domain and generates a square wave at the note's pitch. An attack/sustain/release envelope shapes the output, which is presented both as a 1-bit tone pin and as a 16-bit signed PCM sample stream at about 48 kHz for the audio codec feeder.

## Interface
Parameters:
- CLK_HZ, 50_000_000: system clock frequency; used to derive the pitch table.
- SAMPLE_DIV, 1042: clocks per PCM sample (≈48 kHz).
- ENV_TICK, 50_000: clocks per envelope step (1 ms).
- ATTACK_STEP, 8: amplitude increment per envelope step.
- RELEASE_STEP, 4: amplitude decrement per envelope step.

Ports:
- CLOCK_50  in  1: system clock; all logic is on posedge.
- rst_n  in  1: asynchronous reset, active-low. One clock; reset is asynchronous and active-low.
- note  in  4: note code from the sequencer. It is asynchronous to CLOCK_50 (driven from a divided clock). 0 = rest; 1..7 = C4..B4; 8..14 = C5..B5; 15 = C6.
- mute  in  1: synchronous; forces the outputs silent.
- tone_out  out  1: square wave at the current pitch; 0 when silent.
- sample  out  16: signed PCM sample, updated on each sample tick.
- sample_valid  out  1: one-cycle strobe, asserted in the same cycle `sample` updates.
- busy  out  1: high whenever the state is not IDLE.

## Operation
- **Input capture:** `note` passes through a 2-flop synchroniser. A new code is accepted only when two consecutive synchronised samples are equal; this guards against multi-bit skew. The accepted code is held in `cur_note`.
- **Pitch:** `HALF_PERIOD[n] = round(CLK_HZ / (2·f_n))`, 17-bit values. Examples: C4 = 95556, A4 = 56818, C5 = 47778, C6 = 23889.
  - A down-counter loads `HALF_PERIOD[cur_note]-1`.
  - At 0 it toggles `level` and reloads.
- **Envelope:** `amp` is 8-bit unsigned.
  - On each ENV_TICK in ATTACK: `amp = min(255, amp + ATTACK_STEP)`.
  - On each ENV_TICK in RELEASE: `amp = max(0, amp − RELEASE_STEP)`.
  - All arithmetic is 9-bit with saturation.
- **States:**
  - IDLE: `amp` = 0. Accepted nonzero note → ATTACK; `level` set to 1, counter reloaded.
  - ATTACK: `amp` reaches 255 → SUSTAIN. Accepted note 0 → RELEASE.
  - SUSTAIN: accepted note 0 → RELEASE. A different nonzero note → ATTACK with `amp` kept; this is the retrigger.
  - RELEASE: `amp` reaches 0 → IDLE. Accepted nonzero note → ATTACK starting from the current `amp`.
- **Retuning:** any accepted change to a different nonzero note, in any state, reloads the phase counter immediately and sets `level` = 1. The same note held or repeated never retriggers.
- **Sample format:** `mag = {1'b0, amp, 7'b0}`, giving a maximum of 32640. `sample = level ? mag : −mag` (two's complement), so `amp` = 0 gives 0.
- **tone_out:** equals `level & (amp != 0)`.
- **mute:** while high, `tone_out` = 0 and each new sample is 0. The FSM, envelope and phase continue unchanged, so unmuting resumes mid-note.

## Timing
- **Reset values:** `tone_out` 0, `sample` 0x0000, `sample_valid` 0, `busy` 0. State IDLE, `amp` 0, `level` 0, all counters 0.
- **Note latency:** a `note` change is reflected in `cur_note` and the state 3 cycles after the first CLOCK_50 edge that samples it (2 sync + 1 stability). `tone_out` starts toggling one half-period later.
- **Sample tick:** a free-running counter over 0..SAMPLE_DIV−1.
  - `sample_valid` pulses when it wraps.
  - `sample` is registered from the `amp` and `level` of the previous cycle.
  - The first pulse is SAMPLE_DIV cycles after reset release.
- **Envelope tick:** a free-running counter over 0..ENV_TICK−1. An envelope step only happens on its wrap cycle.
- **Simultaneous events:**
  - A note change on an envelope-tick cycle: the transition happens first; the tick applies the new state's step in that same cycle.
  - `amp` reaching 0 in the same cycle a nonzero note is accepted → ATTACK.
- **Reset mid-note:** reset asserted at any time silences all outputs immediately. After release the block waits for a fresh accepted note, even if `note` is still nonzero; that note is accepted after 3 cycles.

## Structure
- **Package `tone_pkg`:** the state enum (IDLE/ATTACK/SUSTAIN/RELEASE), NOTE_W = 4, AMP_W = 8, and the 16-entry HALF_PERIOD constant array (entry 0 unused) computed for CLK_HZ = 50 MHz.
- **Sub-module `note_sync`:** 2-flop synchroniser plus stability compare; outputs `cur_note` and a one-cycle `note_chg` strobe.
- **Top module:** FSM, envelope, phase counter and sample formatter.

## Test plan
- Reset, then `note` = 6 (A4) held: `busy` rises 3 cycles later; `tone_out` period is 113636 cycles; `amp` reaches 255 after 32 envelope ticks; the SUSTAIN sample alternates +32640 / −32640.
- Change to `note` = 0 while in SUSTAIN: RELEASE; `amp` goes 251, 247, … down to 0 after 64 ticks; then IDLE, `busy` = 0, `sample` = 0.
- Change `note` 1 → 8 while in SUSTAIN: counter reloads with 47777, `level` = 1, ATTACK entered with `amp` still 255, then immediately SUSTAIN on the next tick.
- Raise `mute` mid-SUSTAIN for 10 samples: 10 `sample_valid` strobes carry 0 and `tone_out` = 0; after `mute` falls the samples are ±32640 again with phase continuous.
- Glitch `note` 3 → 5 for a single cycle only: no acceptance, no retrigger, pitch unchanged.
- Assert `rst_n` low mid-ATTACK while `note` = 15 stays applied: outputs are 0 immediately; after release `busy` rises 3 cycles later and `tone_out` half-period is 23889.
